// File: rtl/cp0_exc.sv
// cp0_exc: Coprocessor-0 exception state for the multi-cycle MIPS datapath.
// Holds Status (IM/EXL/IE), Cause (IP), EPC and PRId, raises int_req towards
// the controller and captures the restart PC when the controller acknowledges.
//
// Optional build macro CP0_TIMER_EN adds Count (reg 9) / Compare (reg 11).
// When it is set, a Count==Compare match (Compare nonzero) latches a
// timer-pending flag that is ORed into IP[15] alongside hwint[5].
//
// Handshake: int_req is a level request derived from registered state only.
// int_ack is honoured on a rising edge only while int_req is high. On that
// edge epc takes pc and EXL sets, so int_req drops in the following cycle.
// If int_req is low, int_ack is ignored.
module cp0_exc #(
  parameter logic [31:0] PRID = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  hwint,
  input  logic [29:0] pc,
  input  logic        int_ack,
  input  logic        eret,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [29:0] epc,
  output logic        int_req
);

  logic [5:0] im;
  logic       exl;
  logic       ie;
  logic [5:0] ip;
  logic       ack_take;
  logic       wr_sr;
  logic       wr_epc;
  logic [5:0] ip_next;

  assign wr_sr    = we && (addr == 5'd12);
  assign wr_epc   = we && (addr == 5'd14);
  assign ack_take = int_ack && int_req;

  // Request is a pure function of registered state, so there is no input-to-output path.
  assign int_req = (|(ip & im)) & ie & ~exl;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        tflag;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = we && (addr == 5'd9);
  assign wr_compare = we && (addr == 5'd11);
  assign ip_next    = {hwint[5] | tflag, hwint[4:0]};

  // Count free-runs, with a software load taking precedence over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'h0;
    end else if (wr_count) begin
      count <= din;
    end else begin
      count <= count + 32'd1;
    end
  end

  // Compare write also acknowledges the pending timer interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare <= 32'h0;
      tflag   <= 1'b0;
    end else if (wr_compare) begin
      compare <= din;
      tflag   <= 1'b0;
    end else if ((count == compare) && (compare != 32'h0)) begin
      tflag   <= 1'b1;
    end
  end
`else
  assign ip_next = hwint;
`endif

  // Interrupt lines are sampled every cycle into IP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip <= 6'h0;
    end else begin
      ip <= ip_next;
    end
  end

  // Status register: IM/IE follow mtc0, and EXL uses the priority int_ack > eret > mtc0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im  <= 6'h0;
      ie  <= 1'b0;
      exl <= 1'b0;
    end else begin
      if (wr_sr) begin
        im <= din[15:10];
        ie <= din[0];
      end
      if (ack_take) begin
        exl <= 1'b1;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (wr_sr) begin
        exl <= din[1];
      end
    end
  end

  // EPC captures the restart address on an accepted interrupt, otherwise it follows mtc0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc <= 30'h0;
    end else if (ack_take) begin
      epc <= pc;
    end else if (wr_epc) begin
      epc <= din[31:2];
    end
  end

  // mfc0 read mux, combinational from addr.
  always_comb begin
    dout = 32'h0;
    case (addr)
      5'd12:   dout = {16'h0, im, 8'h0, exl, ie};
      5'd13:   dout = {16'h0, ip, 3'b000, 5'b00000, 2'b00};
      5'd14:   dout = {epc, 2'b00};
      5'd15:   dout = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    dout = count;
      5'd11:   dout = compare;
`endif
      default: dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed bench for cp0_exc (default build, timer disabled).
// A reference model of the architectural registers is advanced on every edge,
// and the outputs are compared against it at each falling edge. Literal
// expectations along the sequence pin both the DUT and the model.
module tb_cp0_exc;

  logic        clk;
  logic        rst_n;
  logic [5:0]  hwint;
  logic [29:0] pc;
  logic        int_ack;
  logic        eret;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [29:0] epc;
  logic        int_req;

  int vectors;
  int miscompares;

  cp0_exc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hwint   (hwint),
    .pc      (pc),
    .int_ack (int_ack),
    .eret    (eret),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .epc     (epc),
    .int_req (int_req)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the architectural state.
  logic [5:0]  m_im;
  logic        m_exl;
  logic        m_ie;
  logic [5:0]  m_ip;
  logic [29:0] m_epc;

  function automatic logic m_req();
    return ((m_ip & m_im) != 6'h0) && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == 5'd12) v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
    if (a == 5'd13) v = 32'(m_ip) << 10;
    if (a == 5'd14) v = 32'(m_epc) * 4;
    if (a == 5'd15) v = 32'h0001_8000;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_im <= 0; m_exl <= 0; m_ie <= 0; m_ip <= 0; m_epc <= 0;
    end else begin
      logic taken;
      taken = int_ack && m_req();
      m_ip <= hwint;
      if (we && addr == 5'd12) begin
        m_im <= din[15:10];
        m_ie <= din[0];
      end
      if (taken)        m_exl <= 1'b1;
      else if (eret)    m_exl <= 1'b0;
      else if (we && addr == 5'd12) m_exl <= din[1];
      if (taken)        m_epc <= pc;
      else if (we && addr == 5'd14) m_epc <= din[31:2];
    end
  end

  // Scoreboard check: one vector per call.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("cmp_int_req", 32'(int_req), 32'(m_req()));
    check("cmp_epc", 32'(epc), 32'(m_epc));
    check("cmp_dout", dout, m_read(addr));
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; int_ack = 0; eret = 0;
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; addr = a; din = d;
    step();
    we = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 0; hwint = 0; pc = 0; idle(); addr = 0; din = 0;
    step(); step();
    check("rst_int_req", 32'(int_req), 32'h0);
    check("rst_epc", 32'(epc), 32'h0);
    #2 rst_n = 1;
    step();

    // Reset values of the readable registers.
    read_chk("rd_sr_rst", 5'd12, 32'h0);
    read_chk("rd_cause_rst", 5'd13, 32'h0);
    read_chk("rd_epc_rst", 5'd14, 32'h0);
    read_chk("rd_prid", 5'd15, 32'h0001_8000);
    check("int_req_rst", 32'(int_req), 32'h0);

    // Enable IM[10] and IE, then raise hwint[0].
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001;
    #1 check("req_before_ip", 32'(int_req), 32'h0);
    step();
    check("req_after_ip", 32'(int_req), 32'h1);

    // Acknowledge the interrupt.
    int_ack = 1; pc = 30'h0000_0C03;
    step();
    int_ack = 0;
    check("epc_taken", 32'(epc), 32'h0000_0C03);
    read_chk("rd_epc_taken", 5'd14, 32'h0000_300C);
    read_chk("rd_sr_exl", 5'd12, 32'h0000_0403);
    check("req_in_handler", 32'(int_req), 32'h0);

    // eret while the level is still held re-raises the request.
    eret = 1;
    step();
    eret = 0;
    check("req_reraise", 32'(int_req), 32'h1);
    check("epc_after_eret", 32'(epc), 32'h0000_0C03);

    // Take it again, drop the line first, then return.
    int_ack = 1; pc = 30'h0000_0010;
    step();
    int_ack = 0; hwint = 0;
    step();
    eret = 1;
    step();
    eret = 0;
    check("req_dropped", 32'(int_req), 32'h0);
    read_chk("rd_sr_clean", 5'd12, 32'h0000_0401);

    // A pending line that is masked out does not raise a request.
    hwint = 6'b000010;
    step(); step();
    check("req_masked", 32'(int_req), 32'h0);
    read_chk("rd_cause_ip11", 5'd13, 32'h0000_0800);

    // Simultaneous int_ack, mtc0 to EPC and eret: int_ack wins.
    hwint = 6'b000011;
    step();
    check("req_unmasked", 32'(int_req), 32'h1);
    int_ack = 1; pc = 30'h0000_0ABC; eret = 1; we = 1; addr = 5'd14; din = 32'h0000_1000;
    step();
    idle();
    check("epc_ack_wins", 32'(epc), 32'h0000_0ABC);
    read_chk("rd_sr_ack_wins", 5'd12, 32'h0000_0403);

    // int_ack with no request pending changes nothing.
    int_ack = 1; pc = 30'h0000_0055;
    step();
    int_ack = 0;
    check("epc_ack_ignored", 32'(epc), 32'h0000_0ABC);

    // Software EPC write, and writes to read-only or unmapped registers are ignored.
    mtc0(5'd14, 32'h0000_1000);
    check("epc_mtc0", 32'(epc), 32'h0000_0400);
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'h1234_5678);
    mtc0(5'd9, 32'hFFFF_FFFF);
    read_chk("rd_cause_ro", 5'd13, 32'h0000_0C00);
    read_chk("rd_prid_ro", 5'd15, 32'h0001_8000);
    read_chk("rd_unmapped", 5'd9, 32'h0);

    // eret beats a concurrent mtc0 that would set EXL.
    eret = 1; we = 1; addr = 5'd12; din = 32'h0000_0C03;
    step();
    idle();
    read_chk("rd_sr_eret_wins", 5'd12, 32'h0000_0C01);
    check("req_after_eret", 32'(int_req), 32'h1);

    // Asynchronous reset in the middle of a handler.
    int_ack = 1; pc = 30'h0000_0777;
    step();
    int_ack = 0;
    check("epc_before_rst", 32'(epc), 32'h0000_0777);
    addr = 5'd12;
    #1 rst_n = 0;
    #1;
    check("async_rst_sr", dout, 32'h0);
    check("async_rst_epc", 32'(epc), 32'h0);
    check("async_rst_req", 32'(int_req), 32'h0);
    step();
    rst_n = 1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
